// File: rtl/rsd4_pkg.sv
// Shared types and helpers for the radix-4 signed-digit on-the-fly converter.
package rsd4_pkg;

  localparam int RSD4_RADIX = 4;

  typedef logic [2:0] rsd4_digit_t;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } otf_state_e;

  // Sign-magnitude decode; the -0 encoding (3'b100) yields 0.
  function automatic int signed rsd4_decode(input rsd4_digit_t dig);
    int signed mag;
    mag = int'(dig[1:0]);
    return dig[2] ? -mag : mag;
  endfunction

endpackage

// File: rtl/rsd4_otf_step.sv
// Combinational on-the-fly conversion step: appends one radix-4 digit to the
// pair (Q, QM = Q - 1) without any carry propagation.
module rsd4_otf_step
  import rsd4_pkg::*;
#(
  parameter int OUT_W = 17
) (
  input  logic [OUT_W-1:0] q_i,
  input  logic [OUT_W-1:0] qm_i,
  input  logic signed [2:0] d_i,
  output logic [OUT_W-1:0] q_o,
  output logic [OUT_W-1:0] qm_o
);

  localparam int DW = $clog2(RSD4_RADIX);

  logic signed [3:0] d_w;
  logic signed [3:0] d_p4;
  logic signed [3:0] d_m1;
  logic signed [3:0] d_p3;

  assign d_w  = {d_i[2], d_i};
  assign d_p4 = d_w + 4'sd4;
  assign d_m1 = d_w - 4'sd1;
  assign d_p3 = d_w + 4'sd3;

  // Negative digits borrow from QM so the shifted prefix never needs a carry.
  assign q_o  = !d_w[3]        ? {q_i[OUT_W-DW-1:0], d_w[DW-1:0]}
                               : {qm_i[OUT_W-DW-1:0], d_p4[DW-1:0]};
  assign qm_o = (d_w > 4'sd0)  ? {q_i[OUT_W-DW-1:0], d_m1[DW-1:0]}
                               : {qm_i[OUT_W-DW-1:0], d_p3[DW-1:0]};

endmodule

// File: rtl/rsd4_otf_converter.sv
// Serial RSD4 (MSD first) to two's-complement converter with valid/ready on both sides.
// Optional macro RSD4_OTF_BACK_TO_BACK_EN lets the next word's MSD overlap the output handshake.
//
// state   | meaning
// COLLECT | accepting digits, accumulating Q/QM
// OUTPUT  | result presented, waiting for out_ready
module rsd4_otf_converter
  import rsd4_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int RADIX_BITS = 3,
  localparam int OUT_W      = 2*NUM_DIGITS+1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RADIX_BITS-1:0] in_digit,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_W-1:0]      out_value,
  output logic                  out_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS-1);

  otf_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] q_q, q_d, qm_q, qm_d;
  logic [OUT_W-1:0] out_value_q, out_value_d;
  logic             out_zero_q, out_zero_d;
  logic             out_valid_q, out_valid_d;

  logic signed [2:0] d_dec;
  logic [OUT_W-1:0]  q_next, qm_next;
  logic              beat, out_hs;

  assign d_dec = 3'(rsd4_decode(rsd4_digit_t'(in_digit)));

  // Q/QM already sit at their reset values in OUTPUT, so an overlapped MSD
  // can use the same step path as any other digit.
  rsd4_otf_step #(.OUT_W(OUT_W)) u_step (
    .q_i  (q_q),
    .qm_i (qm_q),
    .d_i  (d_dec),
    .q_o  (q_next),
    .qm_o (qm_next)
  );

  always_comb begin
    in_ready = 1'b0;
    if (state_q == COLLECT) begin
      in_ready = 1'b1;
    end else begin
`ifdef RSD4_OTF_BACK_TO_BACK_EN
      in_ready = out_ready;
`else
      in_ready = 1'b0;
`endif
    end
  end

  assign beat   = in_valid & in_ready;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    qm_d        = qm_q;
    out_value_d = out_value_q;
    out_zero_d  = out_zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      COLLECT: begin
        if (beat) begin
          if (cnt_q == CNT_LAST) begin
            out_value_d = q_next;
            out_zero_d  = (q_next == '0);
            out_valid_d = 1'b1;
            q_d         = '0;
            qm_d        = '1;
            cnt_d       = '0;
            state_d     = OUTPUT;
          end else begin
            q_d   = q_next;
            qm_d  = qm_next;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
`ifdef RSD4_OTF_BACK_TO_BACK_EN
        if (beat) begin
          q_d   = q_next;
          qm_d  = qm_next;
          cnt_d = CNT_W'(1);
        end
`endif
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      q_q         <= '0;
      qm_q        <= '1;
      out_value_q <= '0;
      out_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      out_value_q <= out_value_d;
      out_zero_q  <= out_zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_value = out_value_q;
  assign out_zero  = out_zero_q;
  assign out_valid = out_valid_q;

endmodule
